// File: rtl/mem_sram_ctrl_if.sv
// Bus bundle between the MEM-stage pipeline, the SRAM access controller and the external SRAM.
// The slave side is the controller; the master side is the pipeline plus SRAM environment.
interface mem_sram_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic              mem_read_en;
    logic              mem_write_en;
    logic [31:0]       alu_res;
    logic [31:0]       val_rm;
    logic [31:0]       value;
    logic              ready;
    logic              freeze;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic              sram_we_n;
    logic [31:0]       sram_rdata;

    modport slave (
        input  mem_read_en, mem_write_en, alu_res, val_rm, sram_rdata,
        output value, ready, freeze, sram_addr, sram_wdata, sram_we_n
    );

    modport master (
        output mem_read_en, mem_write_en, alu_res, val_rm, sram_rdata,
        input  value, ready, freeze, sram_addr, sram_wdata, sram_we_n
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// MEM-stage SRAM controller: runs one fixed-latency access per load/store request and
// holds the pipeline frozen until it completes; load data is returned on value.
module mem_sram_ctrl #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_W      = 18
) (
    input  logic            clk,
    input  logic            rst,
    mem_sram_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              op_wr_q, op_wr_d;
    logic [31:0]       value_q, value_d;
    logic              ready_q, ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_n_q, we_n_d;
    logic              req_s;

    // Byte-offset bits and address bits above the SRAM range are deliberately dropped.
    logic              unused_s;
    assign unused_s = ^{bus.alu_res[1:0], bus.alu_res[31:ADDR_W+2]};

    assign req_s = bus.mem_read_en | bus.mem_write_en;

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        value_d = value_q;
        ready_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_n_d  = we_n_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    addr_d  = bus.alu_res[ADDR_W+1:2];
                    wdata_d = bus.val_rm;
                    op_wr_d = bus.mem_write_en;
                    we_n_d  = ~bus.mem_write_en;
                    cnt_d   = CNT_INIT;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    we_n_d  = 1'b1;
                    ready_d = 1'b1;
                    if (!op_wr_q) begin
                        value_d = bus.sram_rdata;
                    end else begin
                        value_d = value_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // The frozen pipeline still presents the finished request here, so it is ignored.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
                we_n_d  = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            value_q <= 32'd0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            value_q <= value_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_n_q  <= we_n_d;
        end
    end

    assign bus.value      = value_q;
    assign bus.ready      = ready_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_we_n  = we_n_q;
    assign bus.freeze     = (req_s && (state_q == ST_IDLE)) || (state_q == ST_ACCESS);

endmodule

// File: doc/mem_sram_ctrl.md
# mem_sram_ctrl

Multi-cycle memory-access controller for the MEM stage of the ARM pipeline. Takes the EXE stage's load/store request (address from the ALU, store data from Rm), runs a fixed-latency access on an external single-port synchronous SRAM, and freezes the pipeline until the access completes. It supplies the load data to the MEM/WB register.

## Interface
Parameters:
- WAIT_CYCLES, 5, number of SRAM access cycles per request; legal range 1..15
- ADDR_W, 18, SRAM word-address width

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge
- rst  input  1  reset, asynchronous, active-low
- mem_read_en  input  1  load request from EXE/MEM register
- mem_write_en  input  1  store request from EXE/MEM register
- alu_res  input  32  byte address
- val_rm  input  32  store data
- value  output  32  load result, registered
- ready  output  1  one-cycle pulse: access complete
- freeze  output  1  stall to all upstream pipeline registers and the PC
- sram_addr  output  ADDR_W  SRAM word address, registered
- sram_wdata  output  32  SRAM write data, registered
- sram_we_n  output  1  SRAM write strobe, active-low, registered
- sram_rdata  input  32  SRAM read data, valid by the last access cycle

## Operation
- State machine: IDLE, ACCESS, DONE.
- IDLE:
  - A request is mem_read_en | mem_write_en.
  - On a request, latch sram_addr = alu_res[ADDR_W+1:2] (low two bits ignored), sram_wdata = val_rm, and op = write if mem_write_en else read.
  - Load cnt = WAIT_CYCLES-1, then go to ACCESS.
  - sram_we_n goes low on the same edge for a write.
- ACCESS:
  - Decrement cnt each cycle.
  - When cnt == 0: go to DONE; deassert sram_we_n; for a read, capture value <= sram_rdata.
- DONE: ready = 1, then unconditionally go to IDLE. Request inputs are ignored in DONE, because the frozen pipeline still holds the completed request.
- Both enables asserted: treated as a write; value is unchanged.
- Writes never modify value. value holds the last load result until the next read completes.
- freeze = request & (state == IDLE) | (state == ACCESS). This is combinational and 0 in DONE.
- rst low, at any time including mid-access:
  - state returns to IDLE, cnt = 0.
  - value = 0, sram_addr = 0, sram_wdata = 0, sram_we_n = 1, ready = 0.
  - An aborted write may leave the target word undefined. This is acceptable.

## Timing
- Request first seen in cycle 0 (IDLE). ACCESS occupies cycles 1..WAIT_CYCLES. DONE is cycle WAIT_CYCLES+1.
- freeze is high for WAIT_CYCLES+1 consecutive cycles (cycles 0..WAIT_CYCLES) and low in DONE. The pipeline advances at the end of DONE.
- value is valid from the start of DONE and stable until the next completed read.
- sram_we_n is low for exactly WAIT_CYCLES cycles (cycles 1..WAIT_CYCLES). sram_addr and sram_wdata are stable throughout.
- Back-to-back requests: a new request seen in the IDLE cycle after DONE starts immediately. There are no bubble cycles other than DONE.
- No request: the block stays in IDLE with freeze = 0, ready = 0, sram_we_n = 1.
- Reset values of all outputs are as listed under Operation. freeze is 0 after reset unless a request is present.

## Test plan
- Reset: hold rst low with requests driven -> value = 0, ready = 0, sram_we_n = 1, state IDLE. After release with no request, freeze = 0.
- Store then load, WAIT_CYCLES = 5:
  - Write val_rm = 0xDEADBEEF at alu_res = 0x400 -> sram_addr = 0x100, sram_we_n low for 5 cycles, freeze high for 6 cycles, ready pulses on cycle 6.
  - Read 0x400 -> value = 0xDEADBEEF in DONE; freeze high 6 cycles.
- Back-to-back loads of 0x10 and 0x14, holding inputs while frozen -> exactly two ready pulses 7 cycles apart. value = mem[4], then mem[5]. No third access is started from the held inputs in DONE.
- Simultaneous mem_read_en = mem_write_en = 1, val_rm = 0x12345678 at 0x8 -> write performed (sram_we_n low), value unchanged. A later read of 0x8 returns 0x12345678.
- Reset mid-access: assert rst low in ACCESS cycle 3 of a read -> immediately IDLE, value = 0, sram_we_n = 1, no ready pulse. The next request completes normally.
- WAIT_CYCLES = 1: read -> freeze high 2 cycles, ready on cycle 2, correct data captured.
